wb_stage_buffer: RTL and testbench

Parametrised, elastic MEM→WB pipeline buffer. Every output is registered, and it holds two entries: a head slot and a skid slot. It carries load data, ALU/register data, destination register, and write-back controls. It adds several things a plain pipeline register lacks: a valid/ready handshake so WB back-pressure does not drop instructions, a synchronous flush, x0-write suppression, a pre-muxed write-back result, and a forwarding port for hazard logic.

---
 rtl/wb_stage_buffer.sv | 126 ++++++++++++
 tb/tb_wb_stage_buffer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_buffer.sv
// Elastic two-entry MEM->WB buffer: head slot feeds the outputs, skid slot absorbs one
// extra entry under back-pressure. Adds flush, x0-write suppression and a forwarding port.
module wb_stage_buffer #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RD_W         = 5,
  parameter int unsigned CTRL_W       = 4,
  parameter bit          SUPPRESS_RD0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic [DATA_W-1:0] in_reg_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_regwrite,
  input  logic              in_memtoreg,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_read_data,
  output logic [DATA_W-1:0] out_reg_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_regwrite,
  output logic              out_memtoreg,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_wb_data,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        count
);

  typedef struct packed {
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] reg_data;
    logic [RD_W-1:0]   rd;
    logic              regwrite;
    logic              memtoreg;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t     in_entry;
  entry_t     head_q, head_d;
  entry_t     skid_q, skid_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  always_comb begin
    in_entry           = '0;
    in_entry.read_data = in_read_data;
    in_entry.reg_data  = in_reg_data;
    in_entry.rd        = in_rd;
    in_entry.memtoreg  = in_memtoreg;
    in_entry.ctrl      = in_ctrl;
    // Writes to x0 are dropped here so WB and forwarding never see them.
    in_entry.regwrite  = in_regwrite & (!SUPPRESS_RD0 || (in_rd != '0));
  end

  // in_ready depends only on registered occupancy.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case (count_q)
        2'd0: begin
          if (push) begin
            head_d  = in_entry;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_d = in_entry;
          end else if (push) begin
            skid_d  = in_entry;
            count_d = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_d  = skid_q;
            count_d = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign out_read_data = head_q.read_data;
  assign out_reg_data  = head_q.reg_data;
  assign out_rd        = head_q.rd;
  assign out_memtoreg  = head_q.memtoreg;
  assign out_ctrl      = head_q.ctrl;
  assign out_regwrite  = head_q.regwrite & out_valid;
  assign out_wb_data   = head_q.memtoreg ? head_q.read_data : head_q.reg_data;
  assign fwd_valid     = out_regwrite & (head_q.rd != '0);
  assign fwd_rd        = head_q.rd;
  assign fwd_data      = out_wb_data;
  assign count         = count_q;

endmodule

// File: tb/tb_wb_stage_buffer.sv
// Bench for wb_stage_buffer: queue-based reference model checked every cycle, plus directed
// literal expectations. A second instance runs with x0 suppression disabled.
module tb_wb_stage_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_read_data, in_reg_data;
  logic [4:0]  in_rd;
  logic        in_regwrite, in_memtoreg;
  logic [3:0]  in_ctrl;
  logic        out_ready;

  logic        in_ready, out_valid, out_regwrite, out_memtoreg, fwd_valid;
  logic [31:0] out_read_data, out_reg_data, out_wb_data, fwd_data;
  logic [4:0]  out_rd, fwd_rd;
  logic [3:0]  out_ctrl;
  logic [1:0]  count;

  logic        in_ready2, out_valid2, out_regwrite2, out_memtoreg2, fwd_valid2;
  logic [31:0] out_read_data2, out_reg_data2, out_wb_data2, fwd_data2;
  logic [4:0]  out_rd2, fwd_rd2;
  logic [3:0]  out_ctrl2;
  logic [1:0]  count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_stage_buffer #(.DATA_W(32), .RD_W(5), .CTRL_W(4), .SUPPRESS_RD0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_read_data(in_read_data), .in_reg_data(in_reg_data), .in_rd(in_rd),
    .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_read_data(out_read_data),
    .out_reg_data(out_reg_data), .out_rd(out_rd), .out_regwrite(out_regwrite),
    .out_memtoreg(out_memtoreg), .out_ctrl(out_ctrl), .out_wb_data(out_wb_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .count(count)
  );

  wb_stage_buffer #(.DATA_W(32), .RD_W(5), .CTRL_W(4), .SUPPRESS_RD0(1'b0)) dut_nosup (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_read_data(in_read_data), .in_reg_data(in_reg_data), .in_rd(in_rd),
    .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_ctrl(in_ctrl),
    .out_valid(out_valid2), .out_ready(out_ready), .out_read_data(out_read_data2),
    .out_reg_data(out_reg_data2), .out_rd(out_rd2), .out_regwrite(out_regwrite2),
    .out_memtoreg(out_memtoreg2), .out_ctrl(out_ctrl2), .out_wb_data(out_wb_data2),
    .fwd_valid(fwd_valid2), .fwd_rd(fwd_rd2), .fwd_data(fwd_data2), .count(count2)
  );

  typedef struct {
    logic [31:0] read_data;
    logic [31:0] reg_data;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memtoreg;
    logic [3:0]  ctrl;
  } ent_t;

  ent_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two entries, raw regwrite kept as pushed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      bit   do_pop, do_push;
      ent_t e;
      do_pop  = (q.size() > 0) && out_ready;
      do_push = in_valid && (q.size() < 2) && !flush;
      e.read_data = in_read_data;
      e.reg_data  = in_reg_data;
      e.rd        = in_rd;
      e.regwrite  = in_regwrite;
      e.memtoreg  = in_memtoreg;
      e.ctrl      = in_ctrl;
      if (flush) begin
        q.delete();
      end else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    int n;
    n = q.size();
    check("m_count", {62'd0, count}, n);
    check("m_in_ready", {63'd0, in_ready}, {63'd0, n < 2});
    check("m_out_valid", {63'd0, out_valid}, {63'd0, n != 0});
    check("m2_count", {62'd0, count2}, n);
    check("m2_out_valid", {63'd0, out_valid2}, {63'd0, n != 0});
    if (n == 0) begin
      check("m_rw_idle", {63'd0, out_regwrite}, 64'd0);
      check("m_fwd_idle", {63'd0, fwd_valid}, 64'd0);
      check("m2_rw_idle", {63'd0, out_regwrite2}, 64'd0);
      check("m2_fwd_idle", {63'd0, fwd_valid2}, 64'd0);
    end else begin
      ent_t h;
      logic [31:0] wb;
      h  = q[0];
      wb = h.memtoreg ? h.read_data : h.reg_data;
      check("m_read_data", {32'd0, out_read_data}, {32'd0, h.read_data});
      check("m_reg_data", {32'd0, out_reg_data}, {32'd0, h.reg_data});
      check("m_rd", {59'd0, out_rd}, {59'd0, h.rd});
      check("m_memtoreg", {63'd0, out_memtoreg}, {63'd0, h.memtoreg});
      check("m_ctrl", {60'd0, out_ctrl}, {60'd0, h.ctrl});
      check("m_wb_data", {32'd0, out_wb_data}, {32'd0, wb});
      check("m_fwd_data", {32'd0, fwd_data}, {32'd0, wb});
      check("m_fwd_rd", {59'd0, fwd_rd}, {59'd0, h.rd});
      check("m_regwrite", {63'd0, out_regwrite}, {63'd0, h.regwrite && h.rd != 0});
      check("m_fwd_valid", {63'd0, fwd_valid}, {63'd0, h.regwrite && h.rd != 0});
      check("m2_wb_data", {32'd0, out_wb_data2}, {32'd0, wb});
      check("m2_rd", {59'd0, out_rd2}, {59'd0, h.rd});
      check("m2_regwrite", {63'd0, out_regwrite2}, {63'd0, h.regwrite});
      check("m2_fwd_valid", {63'd0, fwd_valid2}, {63'd0, h.regwrite && h.rd != 0});
    end
  end

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] rdata,
                       input logic [31:0] regd, input logic rw, input logic m2r,
                       input logic [3:0] ctrl);
    in_valid     = v;
    in_rd        = rd;
    in_read_data = rdata;
    in_reg_data  = regd;
    in_regwrite  = rw;
    in_memtoreg  = m2r;
    in_ctrl      = ctrl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    #2;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_count", {62'd0, count}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_wb_data", {32'd0, out_wb_data}, 64'd0);
    check("rst_rd", {59'd0, out_rd}, 64'd0);
    check("rst_ctrl", {60'd0, out_ctrl}, 64'd0);
    check("rst_fwd", {26'd0, fwd_valid, fwd_rd, fwd_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'(i), 32'(i * 7), 32'h100 + 32'(i), 1'b1, 1'b0, 4'(i));
      step();
      check("stream_wb", {32'd0, out_wb_data}, 64'h100 + 64'(i));
      check("stream_rd", {59'd0, out_rd}, 64'(i));
      check("stream_count", {62'd0, count}, 64'd1);
    end
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    step();
    check("stream_drain", {62'd0, count}, 64'd0);

    // Back-pressure: A, B fill the buffer, C waits.
    out_ready = 1'b0;
    drive(1'b1, 5'd3, 32'd0, 32'hA, 1'b1, 1'b0, 4'd1);
    step();
    drive(1'b1, 5'd4, 32'd0, 32'hB, 1'b1, 1'b0, 4'd2);
    step();
    check("bp_count", {62'd0, count}, 64'd2);
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 5'd5, 32'd0, 32'hC, 1'b1, 1'b0, 4'd3);
    step();
    check("bp_hold_rd", {59'd0, out_rd}, 64'd3);
    check("bp_hold_count", {62'd0, count}, 64'd2);
    out_ready = 1'b1;
    step();
    check("bp_b_rd", {59'd0, out_rd}, 64'd4);
    check("bp_b_count", {62'd0, count}, 64'd1);
    step();
    check("bp_c_rd", {59'd0, out_rd}, 64'd5);
    check("bp_c_wb", {32'd0, out_wb_data}, 64'hC);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    step();
    check("bp_empty", {63'd0, out_valid}, 64'd0);

    // Write-back mux and forwarding.
    out_ready = 1'b0;
    drive(1'b1, 5'd7, 32'hDEADBEEF, 32'h1234, 1'b1, 1'b1, 4'd9);
    step();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    check("mux_wb", {32'd0, out_wb_data}, 64'hDEADBEEF);
    check("mux_fwd_data", {32'd0, fwd_data}, 64'hDEADBEEF);
    check("mux_fwd_rd", {59'd0, fwd_rd}, 64'd7);
    check("mux_fwd_valid", {63'd0, fwd_valid}, 64'd1);
    out_ready = 1'b1;
    step();

    // x0 suppression.
    out_ready = 1'b0;
    drive(1'b1, 5'd0, 32'h55, 32'h66, 1'b1, 1'b0, 4'd4);
    step();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    check("x0_valid", {63'd0, out_valid}, 64'd1);
    check("x0_regwrite", {63'd0, out_regwrite}, 64'd0);
    check("x0_fwd", {63'd0, fwd_valid}, 64'd0);
    check("x0_nosup_regwrite", {63'd0, out_regwrite2}, 64'd1);
    check("x0_nosup_fwd", {63'd0, fwd_valid2}, 64'd0);
    out_ready = 1'b1;
    step();

    // Flush with a full buffer and a same-cycle push.
    out_ready = 1'b0;
    drive(1'b1, 5'd9, 32'd0, 32'h9, 1'b1, 1'b0, 4'd0);
    step();
    drive(1'b1, 5'd10, 32'd0, 32'h10, 1'b1, 1'b0, 4'd0);
    step();
    check("fl_full", {62'd0, count}, 64'd2);
    flush = 1'b1;
    drive(1'b1, 5'd11, 32'd0, 32'h11, 1'b1, 1'b0, 4'd0);
    step();
    flush = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    check("fl_count", {62'd0, count}, 64'd0);
    check("fl_valid", {63'd0, out_valid}, 64'd0);
    check("fl_regwrite", {63'd0, out_regwrite}, 64'd0);
    check("fl_fwd", {63'd0, fwd_valid}, 64'd0);
    out_ready = 1'b1;
    step();
    check("fl_no_ghost", {63'd0, out_valid}, 64'd0);
    // Flush with one entry and a pending push.
    drive(1'b1, 5'd12, 32'd0, 32'h12, 1'b1, 1'b0, 4'd0);
    out_ready = 1'b0;
    step();
    flush = 1'b1;
    drive(1'b1, 5'd13, 32'd0, 32'h13, 1'b1, 1'b0, 4'd0);
    step();
    flush = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    check("fl1_count", {62'd0, count}, 64'd0);

    // Asynchronous reset with a full buffer.
    drive(1'b1, 5'd14, 32'd0, 32'h14, 1'b1, 1'b0, 4'd0);
    step();
    drive(1'b1, 5'd15, 32'd0, 32'h15, 1'b1, 1'b0, 4'd0);
    step();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    check("ar_full", {62'd0, count}, 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {63'd0, out_valid}, 64'd0);
    check("ar_count", {62'd0, count}, 64'd0);
    check("ar_fwd", {63'd0, fwd_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("ar_in_ready", {63'd0, in_ready}, 64'd1);
    drive(1'b1, 5'd16, 32'd0, 32'h16, 1'b1, 1'b0, 4'd0);
    step();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    check("ar_first_push", {59'd0, out_rd}, 64'd16);
    out_ready = 1'b1;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
